// File: rtl/oram_posmap_ctrl_pkg.sv
// Shared types and constants for the ORAM position-map stage.
//   memory_pos     : one position-map entry {pos, empty_n}
//   path_cmd_t     : command kind sent to the path engine
//   posmap_state_e : position-map controller states
//   lfsr_step      : one Galois right-shift step of the leaf LFSR
package oramPkg;

  localparam int unsigned TREE_DEPTH = 4;
  localparam int unsigned POS_W      = TREE_DEPTH - 1;
  localparam int unsigned LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             empty_n;
  } memory_pos;

  typedef enum logic {
    PATH_ACCESS = 1'b0,
    PATH_FLUSH  = 1'b1
  } path_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FLUSH  = 2'd3
  } posmap_state_e;

  // Galois right-shift: fold the taps in whenever a 1 falls out of the lsb.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    lfsr_step = l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
  endfunction

endpackage

// File: rtl/oram_posmap_ctrl_lfsr.sv
// Leaf generator: 16-bit Galois LFSR exposing the next three draws.
// Ports:
//   clk, rst_n   : clock, async active-low reset (loads SEED)
//   step3_en     : advance the LFSR by three steps this cycle
//   r1_c..r3_c   : low POS_W bits of the 1st/2nd/3rd post-step values
module oram_leaf_lfsr
  import oramPkg::*;
#(
  parameter logic [oramPkg::LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int unsigned                POS_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step3_en,
  output logic [POS_W-1:0] r1_c,
  output logic [POS_W-1:0] r2_c,
  output logic [POS_W-1:0] r3_c
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] s1_c, s2_c, s3_c;

  // Three chained steps; draws are the low bits of each post-step value.
  always_comb begin
    s1_c   = lfsr_step(lfsr_q);
    s2_c   = lfsr_step(s1_c);
    s3_c   = lfsr_step(s2_c);
    r1_c   = s1_c[POS_W-1:0];
    r2_c   = s2_c[POS_W-1:0];
    r3_c   = s3_c[POS_W-1:0];
    lfsr_d = step3_en ? s3_c : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  a_seed_nonzero: assert property (@(posedge clk) SEED != '0);
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst_n) lfsr_q != '0);

endmodule

// File: rtl/oram_posmap_ctrl.sv
// Position-map stage in front of the ORAM path engine.
// Looks up (or randomly assigns) a block's leaf, remaps it to a fresh leaf,
// then issues ACCESS {old leaf, new leaf, block, fresh} and FLUSH {flush leaf}.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_valid/ready     : request handshake, req_block = block number
//   path_valid/ready    : command handshake to the path engine
//   path_cmd            : 0 = ACCESS, 1 = FLUSH
//   path_leaf           : ACCESS old leaf / FLUSH flush leaf
//   path_new_leaf       : ACCESS put_back leaf (0 on FLUSH)
//   path_block          : ACCESS block number (0 on FLUSH)
//   path_fresh          : ACCESS block was unmapped (0 on FLUSH)
module oram_posmap_ctrl #(
  parameter int unsigned TREE_DEPTH = oramPkg::TREE_DEPTH,
  parameter int unsigned POS_W      = TREE_DEPTH - 1,
  parameter int unsigned NUM_BLOCKS = 1 << TREE_DEPTH,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TREE_DEPTH-1:0] req_block,
  output logic                  path_valid,
  input  logic                  path_ready,
  output logic                  path_cmd,
  output logic [POS_W-1:0]      path_leaf,
  output logic [POS_W-1:0]      path_new_leaf,
  output logic [TREE_DEPTH-1:0] path_block,
  output logic                  path_fresh
);

  import oramPkg::*;

  localparam int unsigned ENT_POS_W = $bits(memory_pos) - 1;

  posmap_state_e         state_q, state_d;
  logic [TREE_DEPTH-1:0] block_q, block_d;
  logic [POS_W-1:0]      flush_leaf_q, flush_leaf_d;
  memory_pos             table_q [NUM_BLOCKS];
  memory_pos             table_d [NUM_BLOCKS];
  memory_pos             entry_c;
  logic                  lookup_c;
  logic [POS_W-1:0]      r1_c, r2_c, r3_c;

  logic                  req_ready_q, req_ready_d;
  logic                  path_valid_q, path_valid_d;
  path_cmd_t             path_cmd_q, path_cmd_d;
  logic [POS_W-1:0]      path_leaf_q, path_leaf_d;
  logic [POS_W-1:0]      path_new_leaf_q, path_new_leaf_d;
  logic [TREE_DEPTH-1:0] path_block_q, path_block_d;
  logic                  path_fresh_q, path_fresh_d;

  assign lookup_c = (state_q == ST_LOOKUP);
  assign entry_c  = table_q[block_q];

  // Every lookup consumes exactly three draws, mapped or not.
  oram_leaf_lfsr #(
    .SEED  (LFSR_SEED),
    .POS_W (POS_W)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step3_en (lookup_c),
    .r1_c     (r1_c),
    .r2_c     (r2_c),
    .r3_c     (r3_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid)  state_d = ST_LOOKUP;
      ST_LOOKUP:                 state_d = ST_ACCESS;
      ST_ACCESS: if (path_ready) state_d = ST_FLUSH;
      ST_FLUSH:  if (path_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic; command fields load on state entry and then hold.
  always_comb begin
    req_ready_d     = (state_d == ST_IDLE);
    path_valid_d    = (state_d == ST_ACCESS) || (state_d == ST_FLUSH);
    path_cmd_d      = path_cmd_q;
    path_leaf_d     = path_leaf_q;
    path_new_leaf_d = path_new_leaf_q;
    path_block_d    = path_block_q;
    path_fresh_d    = path_fresh_q;
    block_d         = block_q;
    flush_leaf_d    = flush_leaf_q;
    table_d         = table_q;
    case (state_q)
      ST_IDLE: if (req_valid) block_d = req_block;
      ST_LOOKUP: begin
        path_cmd_d      = PATH_ACCESS;
        path_leaf_d     = entry_c.empty_n ? POS_W'(entry_c.pos) : r1_c;
        path_new_leaf_d = r2_c;
        path_block_d    = block_q;
        path_fresh_d    = ~entry_c.empty_n;
        flush_leaf_d    = r3_c;
        table_d[block_q] = '{pos: ENT_POS_W'(r2_c), empty_n: 1'b1};
      end
      ST_ACCESS: if (path_ready) begin
        path_cmd_d      = PATH_FLUSH;
        path_leaf_d     = flush_leaf_q;
        path_new_leaf_d = '0;
        path_block_d    = '0;
        path_fresh_d    = 1'b0;
      end
      ST_FLUSH: if (path_ready) begin
        path_cmd_d      = PATH_ACCESS;
        path_leaf_d     = '0;
        path_new_leaf_d = '0;
        path_block_d    = '0;
        path_fresh_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q     <= 1'b1;
      path_valid_q    <= 1'b0;
      path_cmd_q      <= PATH_ACCESS;
      path_leaf_q     <= '0;
      path_new_leaf_q <= '0;
      path_block_q    <= '0;
      path_fresh_q    <= 1'b0;
      block_q         <= '0;
      flush_leaf_q    <= '0;
      for (int i = 0; i < int'(NUM_BLOCKS); i++) table_q[i] <= '0;
    end else begin
      req_ready_q     <= req_ready_d;
      path_valid_q    <= path_valid_d;
      path_cmd_q      <= path_cmd_d;
      path_leaf_q     <= path_leaf_d;
      path_new_leaf_q <= path_new_leaf_d;
      path_block_q    <= path_block_d;
      path_fresh_q    <= path_fresh_d;
      block_q         <= block_d;
      flush_leaf_q    <= flush_leaf_d;
      table_q         <= table_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign path_valid    = path_valid_q;
  assign path_cmd      = path_cmd_q;
  assign path_leaf     = path_leaf_q;
  assign path_new_leaf = path_new_leaf_q;
  assign path_block    = path_block_q;
  assign path_fresh    = path_fresh_q;

  // The table entry type carries the package leaf width.
  a_pos_w_match: assert property (@(posedge clk) ENT_POS_W == POS_W);

endmodule

// File: tb/tb_oram_posmap_ctrl.sv
// Self-checking bench for oram_posmap_ctrl against a behavioural position-map model.
module tb_oram_posmap_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [TD-1:0] req_block;
  logic          path_valid;
  logic          path_ready;
  logic          path_cmd;
  logic [PW-1:0] path_leaf;
  logic [PW-1:0] path_new_leaf;
  logic [TD-1:0] path_block;
  logic          path_fresh;

  oram_posmap_ctrl #(
    .TREE_DEPTH (TD),
    .POS_W      (PW),
    .NUM_BLOCKS (16),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_block     (req_block),
    .path_valid    (path_valid),
    .path_ready    (path_ready),
    .path_cmd      (path_cmd),
    .path_leaf     (path_leaf),
    .path_new_leaf (path_new_leaf),
    .path_block    (path_block),
    .path_fresh    (path_fresh)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: leaf per block, mapped flag, LFSR as a plain integer.
  logic [15:0] m_lfsr;
  logic [2:0]  m_pos    [16];
  bit          m_mapped [16];

  function automatic logic [15:0] m_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      m_pos[i]    = 3'd0;
      m_mapped[i] = 1'b0;
    end
  endtask

  task automatic model_req(input logic [3:0] blk, output logic [2:0] e_old,
                           output logic [2:0] e_new, output logic [2:0] e_flush,
                           output logic e_fresh);
    logic [2:0] r [3];
    for (int k = 0; k < 3; k++) begin
      m_lfsr = m_next(m_lfsr);
      r[k]   = m_lfsr[2:0];
    end
    e_fresh       = !m_mapped[blk];
    e_old         = m_mapped[blk] ? m_pos[blk] : r[0];
    e_new         = r[1];
    e_flush       = r[2];
    m_pos[blk]    = r[1];
    m_mapped[blk] = 1'b1;
  endtask

  // Values observed on the most recent request.
  logic [2:0] obs_old, obs_new, obs_flush;
  logic       obs_fresh;

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),     32'd1);
    check({tag, "_path_valid"}, 32'(path_valid),    32'd0);
    check({tag, "_cmd"},        32'(path_cmd),      32'd0);
    check({tag, "_leaf"},       32'(path_leaf),     32'd0);
    check({tag, "_new_leaf"},   32'(path_new_leaf), 32'd0);
    check({tag, "_block"},      32'(path_block),    32'd0);
    check({tag, "_fresh"},      32'(path_fresh),    32'd0);
  endtask

  // One request end to end, with optional stalls, busy-time pokes and reset in FLUSH.
  task automatic run_req(input logic [3:0] blk, input int acc_stall, input int fl_stall,
                         input bit poke, input bit abort_in_flush);
    logic [2:0] e_old, e_new, e_flush;
    logic       e_fresh;
    int         n;
    model_req(blk, e_old, e_new, e_flush, e_fresh);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_block = blk;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_block = 4'($urandom);
    check("lookup_valid", 32'(path_valid), 32'd0);
    check("lookup_ready", 32'(req_ready),  32'd0);
    path_ready = (acc_stall == 0);
    @(posedge clk); #1;
    obs_old   = path_leaf;
    obs_new   = path_new_leaf;
    obs_fresh = path_fresh;
    for (int i = 0; i <= acc_stall; i++) begin
      check("acc_valid",    32'(path_valid),    32'd1);
      check("acc_cmd",      32'(path_cmd),      32'd0);
      check("acc_leaf",     32'(path_leaf),     32'(e_old));
      check("acc_new_leaf", 32'(path_new_leaf), 32'(e_new));
      check("acc_block",    32'(path_block),    32'(blk));
      check("acc_fresh",    32'(path_fresh),    32'(e_fresh));
      check("acc_req_ready", 32'(req_ready),    32'd0);
      if (i == acc_stall) begin
        req_valid  = 1'b0;
        path_ready = 1'b1;
      end else if (poke) begin
        req_valid = 1'b1;
        req_block = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    path_ready = (fl_stall == 0);
    obs_flush  = path_leaf;
    for (int i = 0; i <= fl_stall; i++) begin
      check("fl_valid",    32'(path_valid),    32'd1);
      check("fl_cmd",      32'(path_cmd),      32'd1);
      check("fl_leaf",     32'(path_leaf),     32'(e_flush));
      check("fl_new_leaf", 32'(path_new_leaf), 32'd0);
      check("fl_block",    32'(path_block),    32'd0);
      check("fl_fresh",    32'(path_fresh),    32'd0);
      check("fl_req_ready", 32'(req_ready),    32'd0);
      if (abort_in_flush) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        model_reset();
        req_valid  = 1'b0;
        path_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (i == fl_stall) begin
        req_valid  = 1'b0;
        path_ready = 1'b1;
      end else if (poke) begin
        req_valid = 1'b1;
        req_block = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    check_idle_outputs("post");
  endtask

  logic [2:0] first_new [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_block  = '0;
    path_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // First request to block 5: unmapped, known draws from the seed.
    run_req(4'd5, 0, 0, 1'b0, 1'b0);
    check("req1_old",   32'(obs_old),   32'd0);
    check("req1_new",   32'(obs_new),   32'd0);
    check("req1_fresh", 32'(obs_fresh), 32'd1);
    check("req1_flush", 32'(obs_flush), 32'd4);
    check("req1_lfsr",  32'(dut.u_lfsr.lfsr_q), 32'h389C);

    // Second request to block 5: old leaf is the previous new leaf.
    run_req(4'd5, 0, 0, 1'b0, 1'b0);
    check("req2_old",   32'(obs_old),   32'd0);
    check("req2_new",   32'(obs_new),   32'd7);
    check("req2_fresh", 32'(obs_fresh), 32'd0);
    check("req2_flush", 32'(obs_flush), 32'd3);
    check("req2_lfsr",  32'(dut.u_lfsr.lfsr_q), 32'hB313);

    // Backpressure on ACCESS with ignored requests, then on FLUSH.
    run_req(4'($urandom), 5, 0, 1'b1, 1'b0);
    run_req(4'($urandom), 0, 3, 1'b1, 1'b0);
    check("bp_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));

    // Reset during FLUSH, then block 5 must repeat the first-request values.
    run_req(4'd2, 0, 1, 1'b0, 1'b1);
    run_req(4'd5, 0, 0, 1'b0, 1'b0);
    check("rst_old",   32'(obs_old),   32'd0);
    check("rst_new",   32'(obs_new),   32'd0);
    check("rst_fresh", 32'(obs_fresh), 32'd1);
    check("rst_flush", 32'(obs_flush), 32'd4);

    // Two walks over every block.
    for (int b = 0; b < 16; b++) begin
      run_req(4'(b), 0, 0, 1'b0, 1'b0);
      first_new[b] = obs_new;
    end
    for (int b = 0; b < 16; b++) begin
      run_req(4'(b), 0, 0, 1'b0, 1'b0);
      check("walk2_old",   32'(obs_old),   32'(first_new[b]));
      check("walk2_fresh", 32'(obs_fresh), 32'd0);
    end

    // Random traffic with random stalls and busy-time pokes.
    for (int t = 0; t < 40; t++) begin
      run_req(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              1'($urandom), 1'b0);
    end
    check("final_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oram_posmap_ctrl.md
# oram_posmap_ctrl

Synthesizable position-map stage that sits directly upstream of the ORAM tree path engine (fetch / put_back / flush). It accepts one block-number request at a time and looks up the block's current leaf, assigning a random leaf if the block has never been mapped. It then remaps the block to a fresh random leaf and issues two commands downstream: an ACCESS command carrying the old leaf, the new leaf and the block number, followed by a FLUSH command carrying a random flush leaf. Leaves come from an internal 16-bit LFSR, so behaviour is deterministic for a given seed.

## Interface
- TREE_DEPTH, default oramPkg::TREE_DEPTH: tree depth. Block number is TREE_DEPTH bits; legal range ≥2.
- POS_W, default TREE_DEPTH-1: leaf (pos) width.
- NUM_BLOCKS, default 1<<TREE_DEPTH: position-map entries.
- LFSR_SEED, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept; high only in IDLE.
- req_block  in  TREE_DEPTH  requested block number.
- path_valid  out  1  command valid to the path engine.
- path_ready  in  1  path engine accepts command.
- path_cmd  out  1  0 = ACCESS, 1 = FLUSH.
- path_leaf  out  POS_W  ACCESS: old leaf to read. FLUSH: flush leaf.
- path_new_leaf  out  POS_W  ACCESS: leaf for put_back. FLUSH: 0.
- path_block  out  TREE_DEPTH  block number (FLUSH: 0).
- path_fresh  out  1  ACCESS: block was unmapped before this request. FLUSH: 0.

## Operation
- Table: NUM_BLOCKS entries of oramPkg::memory_pos {pos, empty_n}. Reset clears all entries to pos=0, empty_n=0.
- LFSR: Galois, right-shift. Step rule: if lsb=1 then next=(l>>1)^16'hB400, else next=l>>1. A drawn leaf is the low POS_W bits of the post-step value.
- Every accepted request consumes exactly three consecutive draws r1, r2, r3, whether or not the block was mapped.
- States: IDLE → LOOKUP → ACCESS → FLUSH → IDLE.
- IDLE: req_ready=1. On req_valid, latch req_block and go to LOOKUP.
- LOOKUP (1 cycle):
  - Read the entry. old_leaf = entry.pos if empty_n=1, else r1. fresh = ~empty_n.
  - new_leaf = r2, flush_leaf = r3.
  - Write entry ← {pos=r2, empty_n=1}.
  - Advance the LFSR three steps.
- ACCESS: path_valid=1, path_cmd=0, with fields as defined above. Hold all fields stable until path_ready, then go to FLUSH.
- FLUSH: path_valid=1, path_cmd=1, path_leaf=flush_leaf. Hold until path_ready, then go to IDLE.
- Back-to-back: req_ready rises the cycle after the FLUSH handshake. No overlap between requests, so no read/write hazard on the table.
- Repeated requests to one block: each request's ACCESS old leaf equals the previous request's new leaf for that block.

## Timing
- Reset values:
  - req_ready=1, path_valid=0, all path_* fields 0.
  - state=IDLE, LFSR=LFSR_SEED, table cleared.
- Request handshake at edge N: LOOKUP during cycle N+1, ACCESS path_valid=1 from cycle N+2.
- With path_ready tied high: ACCESS for 1 cycle, FLUSH for 1 cycle, req_ready=1 again at N+4. Throughput is 1 request per 4 cycles.
- path_valid, once raised, never drops before handshake. Outputs are registered.
- rst_n low mid-operation: asynchronous return to reset values; any in-flight command is dropped.
- req_valid while not IDLE is ignored (req_ready=0). req_block is sampled only on the handshake edge.

## Structure
- In oramPkg: memory_pos (reused), LFSR_W=16, LFSR_TAPS=16'hB400, and an enum path_cmd_t {PATH_ACCESS, PATH_FLUSH}.
- One sub-module: oram_leaf_lfsr (seed param, step-by-3 enable, outputs r1/r2/r3). The FSM and table live in oram_posmap_ctrl.
- Assertion: LFSR_SEED != 0. LFSR value never 0.

## Test plan
Settings: TREE_DEPTH=4, POS_W=3, seed 16'hACE1, path_ready=1 unless noted.
- Reset: hold rst_n low, then release → req_ready=1, path_valid=0, fields 0. A following request to any block gives path_fresh=1.
- First request, block 5 → ACCESS {leaf=0, new_leaf=0, block=5, fresh=1}, then FLUSH leaf=4. LFSR=16'h389C.
- Second request, block 5 → ACCESS {leaf=0, new_leaf=7, fresh=0}, then FLUSH leaf=3. LFSR=16'hB313.
- Backpressure: path_ready=0 for 5 cycles during ACCESS → fields stable, req_ready=0, req_valid ignored. Release → FLUSH follows, then IDLE.
- Reset asserted during FLUSH → outputs return to reset values immediately. Re-requesting block 5 gives fresh=1 and repeats the first-request values.
- Walk all 16 blocks once, then repeat the walk → every second-pass ACCESS leaf equals that block's first-pass new_leaf, with fresh=0.
